sfp_resize_pipe: RTL

Pipelined, multi-channel signed fixed-point resizer with selectable rounding and overflow handling.
- Converts CH lanes from Q(IN_IW.IN_QW) to Q(OUT_IW.OUT_QW) on a valid/ready stream.
- Reports per-beat overflow and keeps sticky per-channel overflow flags plus a saturating overflow-beat counter.
- Sits between fp_core arithmetic stages, e.g. after multipliers before narrowing to storage width.

---
 rtl/fp_core_pkg.sv | 24 ++
 rtl/sfp_round_lane.sv | 48 ++++
 rtl/sfp_resize_pipe.sv | 111 +++++++++++
 3 files changed

// File: rtl/fp_core_pkg.sv
// Shared fixed-point helpers for fp_core datapath blocks: rounding-mode
// constants and signed saturation bounds for a given word width.
package fp_core_pkg;

  typedef enum int unsigned {
    ROUND_TRUNC   = 0,
    ROUND_HALF_UP = 1,
    ROUND_CONV    = 2
  } round_mode_e;

  typedef struct packed {
    logic [63:0] lo;
    logic [63:0] hi;
  } sat_bounds_t;

  // Two's complement range of a w-bit signed word, sign-extended to 64 bits.
  function automatic sat_bounds_t sat_bounds(input int unsigned w);
    sat_bounds_t b;
    b.hi = (64'(1) << (w - 1)) - 64'(1);
    b.lo = ~b.hi;
    return b;
  endfunction

endpackage

// File: rtl/sfp_round_lane.sv
// Combinational per-channel rounding stage: rescales Q(IN_IW.IN_QW) to
// OUT_QW fractional bits in IN_IW+OUT_QW+1 signed bits (room for the carry).
module sfp_round_lane
  import fp_core_pkg::*;
#(
  parameter int unsigned IN_IW  = 4,
  parameter int unsigned IN_QW  = 8,
  parameter int unsigned OUT_QW = 4,
  parameter int unsigned ROUND  = 0
) (
  input  logic [IN_IW+IN_QW-1:0] i_x,
  output logic [IN_IW+OUT_QW:0]  o_y
);

  localparam int unsigned IN_W = IN_IW + IN_QW;
  localparam int unsigned S1_W = IN_IW + OUT_QW + 1;
  localparam int          D    = int'(IN_QW) - int'(OUT_QW);

  generate
    if (D > 0) begin : g_shr
      localparam int unsigned DS = IN_QW - OUT_QW;

      logic signed [IN_W:0] w_ext;
      logic signed [IN_W:0] w_bias;
      logic signed [IN_W:0] w_sum;

      assign w_ext = {i_x[IN_W-1], i_x};

      // Convergent bias is half-minus-one plus the kept LSB, so exact ties land on even.
      always_comb begin
        w_bias = '0;
        if (ROUND == ROUND_HALF_UP) begin
          w_bias = (IN_W+1)'(1) << (DS - 1);
        end else if (ROUND == ROUND_CONV) begin
          w_bias = ((IN_W+1)'(1) << (DS - 1)) - (IN_W+1)'(1) + (IN_W+1)'(i_x[DS]);
        end
      end

      assign w_sum = w_ext + w_bias;
      assign o_y   = S1_W'(w_sum >>> DS);
    end else begin : g_shl
      localparam int unsigned LS = OUT_QW - IN_QW;

      assign o_y = S1_W'($signed(i_x)) << LS;
    end
  endgenerate

endmodule

// File: rtl/sfp_resize_pipe.sv
// Two-stage multi-channel signed fixed-point resizer (round, then range-reduce)
// on a valid/ready stream, with per-beat, sticky and counted overflow status.
module sfp_resize_pipe
  import fp_core_pkg::*;
#(
  parameter int unsigned IN_IW  = 4,
  parameter int unsigned IN_QW  = 8,
  parameter int unsigned OUT_IW = 2,
  parameter int unsigned OUT_QW = 4,
  parameter int unsigned CH     = 4,
  parameter int unsigned ROUND  = 0,
  parameter int unsigned CLIP   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CH*(IN_IW+IN_QW)-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH*(OUT_IW+OUT_QW)-1:0] out_data,
  output logic [CH-1:0]             out_clip,
  output logic [CH-1:0]             clip_sticky,
  output logic [CNT_W-1:0]          clip_cnt,
  input  logic                      clr
);

  localparam int unsigned IN_W  = IN_IW + IN_QW;
  localparam int unsigned OUT_W = OUT_IW + OUT_QW;
  localparam int unsigned S1_W  = IN_IW + OUT_QW + 1;

  localparam sat_bounds_t       BND    = sat_bounds(OUT_W);
  localparam logic signed [63:0] SAT_HI = BND.hi;
  localparam logic signed [63:0] SAT_LO = BND.lo;

  logic                          w_adv;
  logic                          w_hs;
  logic                          r_s1_valid;
  logic [CH-1:0][S1_W-1:0]       r_s1_data;
  logic [CH-1:0][S1_W-1:0]       w_s1_next;
  logic [CH-1:0][OUT_W-1:0]      w_s2_data;
  logic [CH-1:0]                 w_ovf;

  // Whole pipe advances together; a stalled output freezes both stages.
  assign w_adv    = !out_valid || out_ready;
  assign w_hs     = out_valid && out_ready;
  assign in_ready = w_adv;

  generate
    for (genvar c = 0; c < CH; c++) begin : g_ch
      logic signed [63:0] w_wide;

      sfp_round_lane #(
        .IN_IW (IN_IW),
        .IN_QW (IN_QW),
        .OUT_QW(OUT_QW),
        .ROUND (ROUND)
      ) u_lane (
        .i_x(in_data[c*IN_W +: IN_W]),
        .o_y(w_s1_next[c])
      );

      // Out-of-range values saturate toward their own sign or wrap to the LSBs.
      assign w_wide       = 64'($signed(r_s1_data[c]));
      assign w_ovf[c]     = (w_wide > SAT_HI) || (w_wide < SAT_LO);
      assign w_s2_data[c] = (w_ovf[c] && (CLIP != 0))
                          ? (w_wide[63] ? OUT_W'(SAT_LO) : OUT_W'(SAT_HI))
                          : OUT_W'(w_wide);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s1_data  <= w_s1_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_clip  <= '0;
    end else if (w_adv) begin
      out_valid <= r_s1_valid;
      out_data  <= w_s2_data;
      out_clip  <= w_ovf & {CH{r_s1_valid}};
    end
  end

  // Status follows delivered beats only; clr keeps the beat handed over in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_sticky <= '0;
      clip_cnt    <= '0;
    end else if (clr) begin
      clip_sticky <= w_hs ? out_clip : '0;
      clip_cnt    <= (w_hs && (|out_clip)) ? CNT_W'(1) : '0;
    end else if (w_hs) begin
      clip_sticky <= clip_sticky | out_clip;
      if ((|out_clip) && (clip_cnt != '1)) begin
        clip_cnt <= clip_cnt + CNT_W'(1);
      end
    end
  end

endmodule
